// File: rtl/line_window_pkg.sv
// Shared types for the line_window sliding-window generator: FSM state encoding
// and the check used to reject unsupported window sizes at elaboration.
package line_window_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
  } state_t;

  function automatic bit legal_k(input int k);
    return (k == 3) || (k == 5) || (k == 7);
  endfunction

endpackage

// File: rtl/lw_line_buffer.sv
// Programmable-depth delay line: each enabled cycle emits the sample written
// depth enables earlier. A depth of zero degenerates to a combinational pass-through.
module lw_line_buffer #(
  parameter int N      = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [ADDR_W-1:0] depth,
  input  logic [N-1:0]      sample,
  output logic [N-1:0]      delayed
);

  logic [N-1:0]      mem [2**ADDR_W];
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      ptr <= '0;
    end else if (enable && (depth != '0)) begin
      ptr <= (ptr == depth - 1'b1) ? '0 : ptr + 1'b1;
    end
  end

  // Read-before-write on the same slot yields exactly depth enables of delay.
  always_ff @(posedge clock) begin
    if (enable) begin
      mem[ptr] <= sample;
    end
  end

  assign delayed = (depth == '0) ? sample : mem[ptr];

endmodule

// File: rtl/line_window.sv
// KxK sliding window over a raster pixel stream using K-1 line buffers.
// Optional feature macro WINDOW_POS_EN adds out_col/out_row (window centre coordinate).
module line_window
  import line_window_pkg::*;
#(
  parameter int N         = 8,
  parameter int K         = 3,
  parameter int MAX_WIDTH = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             in_valid,
  input  logic [N-1:0]     in_pixel,
  output logic [K*K*N-1:0] win,
  output logic             out_valid,
  output logic             frame_done,
  output logic             cfg_err
`ifdef WINDOW_POS_EN
  ,
  output logic [15:0]      out_col,
  output logic [15:0]      out_row
`endif
);

  if (!legal_k(K)) begin : g_bad_k
    $error("line_window: K must be 3, 5 or 7");
  end
  if ((2 ** ADDR_W) < MAX_WIDTH) begin : g_bad_addr
    $error("line_window: ADDR_W too small for MAX_WIDTH");
  end

  localparam logic [15:0] K16      = 16'(K);
  localparam logic [15:0] KM1      = 16'(K - 1);
  localparam logic [15:0] FILL_ROW = 16'(K - 2);
  localparam logic [15:0] MAXW16   = 16'(MAX_WIDTH);

  state_t      state, state_n;
  logic [15:0] wid, hgt, col, row;
  logic        accept, last_col, illegal, vld_p0, done_p0;

  assign accept   = in_valid && (state != S_IDLE);
  assign last_col = (col == wid - 16'd1);
  assign illegal  = (width < K16) || (width > MAXW16) || (height < K16);

  always_comb begin
    state_n = state;
    vld_p0  = 1'b0;
    done_p0 = 1'b0;
    case (state)
      S_IDLE: if (!illegal) state_n = S_FILL;
      S_FILL: if (accept && last_col && (row == FILL_ROW)) state_n = S_RUN;
      S_RUN: begin
        vld_p0 = accept && (col >= KM1) && (row >= KM1);
        if (accept && last_col && (row == hgt - 16'd1)) begin
          done_p0 = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wid        <= '0;
      hgt        <= '0;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      out_valid  <= vld_p0;
      frame_done <= done_p0;
      if (state == S_IDLE) begin
        wid     <= width;
        hgt     <= height;
        col     <= '0;
        row     <= '0;
        cfg_err <= illegal;
      end else if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

`ifdef WINDOW_POS_EN
  localparam logic [15:0] HALF = 16'((K - 1) / 2);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_col <= '0;
      out_row <= '0;
    end else if (vld_p0) begin
      out_col <= col - HALF;
      out_row <= row - HALF;
    end
  end
`endif

  // Serial chain: row K-1 takes the live pixel, every upper row is fed by the
  // line buffer that delays the oldest tap of the row below by width-K pixels.
  logic [N-1:0]      taps   [K][K];
  logic [N-1:0]      row_in [K];
  logic [ADDR_W-1:0] lb_depth;
  logic              lb_clear;

  assign row_in[K-1] = in_pixel;
  assign lb_depth    = ADDR_W'(wid - K16);
  assign lb_clear    = (state == S_IDLE);

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    lw_line_buffer #(
      .N      (N),
      .ADDR_W (ADDR_W)
    ) u_lb (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (lb_clear),
      .enable  (accept),
      .depth   (lb_depth),
      .sample  (taps[g+1][0]),
      .delayed (row_in[g])
    );
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          taps[r][c] <= taps[r][c+1];
        end
        taps[r][K-1] <= row_in[r];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_win_r
    for (genvar c = 0; c < K; c++) begin : g_win_c
      assign win[(r*K+c)*N +: N] = taps[r][c];
    end
  end

endmodule

// File: tb/tb_line_window.sv
// Bench for line_window: K=3 and K=5 instances share one stimulus stream and are
// scored against a window model built directly from the accepted pixel raster.
module tb_line_window;

  localparam int MAXW = 4096;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [15:0]  width, height;
  logic         in_valid;
  logic [7:0]   in_pixel;
  logic [71:0]  win3;
  logic [199:0] win5;
  logic         ov3, ov5, fd3, fd5, err3, err5;
`ifdef WINDOW_POS_EN
  logic [15:0]  oc3, or3, oc5, or5;
  logic [15:0]  fc3, fr3, lc3, lr3;
`endif

  always #5 clock = ~clock;

  line_window #(.N(8), .K(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .in_valid(in_valid), .in_pixel(in_pixel), .win(win3), .out_valid(ov3),
    .frame_done(fd3), .cfg_err(err3)
`ifdef WINDOW_POS_EN
    , .out_col(oc3), .out_row(or3)
`endif
  );

  line_window #(.N(8), .K(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .in_valid(in_valid), .in_pixel(in_pixel), .win(win5), .out_valid(ov5),
    .frame_done(fd5), .cfg_err(err5)
`ifdef WINDOW_POS_EN
    , .out_col(oc5), .out_row(or5)
`endif
  );

  typedef struct {
    int w;
    int h;
    int mode;   // 0 ramp continuous, 1 ramp alternating valid, 2 random with gaps, 3 random continuous
    int exp3;
    int exp5;
  } vec_t;

  int           checks = 0;
  int           passed = 0;
  logic [7:0]   sent[$];
  logic [199:0] got3[$], got5[$];
  int           fdc3, fdc5, badv3, badv5;
  bit           need_rst;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    if (ov3) begin
      got3.push_back(200'(win3));
      if (!in_valid) badv3++;
`ifdef WINDOW_POS_EN
      if (got3.size() == 1) begin
        fc3 = oc3;
        fr3 = or3;
      end
      lc3 = oc3;
      lr3 = or3;
`endif
    end
    if (ov5) begin
      got5.push_back(win5);
      if (!in_valid) badv5++;
    end
    if (fd3) fdc3++;
    if (fd5) fdc5++;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    cycle();
    cycle();
    reset_n  = 1'b1;
  endtask

  function automatic logic [199:0] model_win(int k, int w, int r, int c);
    logic [199:0] v = '0;
    for (int rr = 0; rr < k; rr++)
      for (int cc = 0; cc < k; cc++)
        v[(rr*k+cc)*8 +: 8] = sent[(r-(k-1)+rr)*w + (c-(k-1)+cc)];
    return v;
  endfunction

  function automatic int win_errors(int k, int w, int h, logic [199:0] q[$]);
    int idx = 0;
    int bad = 0;
    for (int r = k - 1; r < h; r++)
      for (int c = k - 1; c < w; c++) begin
        if (idx >= q.size()) bad++;
        else if (q[idx] !== model_win(k, w, r, c)) bad++;
        idx++;
      end
    return bad;
  endfunction

  task automatic run_frame(input int w, input int h, input int mode, input int exp3,
                           input int exp5, input string tag);
    bit         e3, e5, phase;
    int         total, i;
    logic [7:0] pix;
    e3 = (w < 3) || (w > MAXW) || (h < 3);
    e5 = (w < 5) || (w > MAXW) || (h < 5);
    width  = 16'(w);
    height = 16'(h);
    if (need_rst) do_reset();
    in_valid = 1'b0;
    sent.delete();
    got3.delete();
    got5.delete();
    fdc3 = 0; fdc5 = 0; badv3 = 0; badv5 = 0;
    cycle();
    total = (e3 && e5) ? 20 : w * h;
    i = 0;
    phase = 1'b0;
    while (i < total) begin
      bit gap;
      gap = (mode == 1) ? phase : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      phase = ~phase;
      if (gap) begin
        in_valid = 1'b0;
        in_pixel = 8'($urandom);
      end else begin
        pix = (mode >= 2) ? 8'($urandom) : 8'((i / w) * 16 + (i % w));
        in_valid = 1'b1;
        in_pixel = pix;
        sent.push_back(pix);
        i++;
      end
      cycle();
    end
    in_valid = 1'b0;
    check($sformatf("%s cfg_err K3", tag), 200'(err3), 200'(e3));
    check($sformatf("%s cfg_err K5", tag), 200'(err5), 200'(e5));
    check($sformatf("%s pulses K3", tag), 200'(got3.size()), 200'(exp3));
    check($sformatf("%s pulses K5", tag), 200'(got5.size()), 200'(exp5));
    check($sformatf("%s frame_done K3", tag), 200'(fdc3), 200'(e3 ? 0 : 1));
    check($sformatf("%s frame_done K5", tag), 200'(fdc5), 200'(e5 ? 0 : 1));
    check($sformatf("%s valid_after_idle", tag), 200'(badv3 + badv5), 200'(0));
    if (!e3) check($sformatf("%s windows K3", tag), 200'(win_errors(3, w, h, got3)), 200'(0));
    if (!e5) check($sformatf("%s windows K5", tag), 200'(win_errors(5, w, h, got5)), 200'(0));
    need_rst = e3 || e5;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{w: 8,    h: 6, mode: 0, exp3: 24, exp5: 8};
    vecs[1] = '{w: 10,   h: 7, mode: 0, exp3: 40, exp5: 18};
    vecs[2] = '{w: 8,    h: 6, mode: 1, exp3: 24, exp5: 8};
    vecs[3] = '{w: 2,    h: 6, mode: 0, exp3: 0,  exp5: 0};
    vecs[4] = '{w: 8,    h: 6, mode: 3, exp3: 24, exp5: 8};
    vecs[5] = '{w: 5000, h: 6, mode: 0, exp3: 0,  exp5: 0};
    vecs[6] = '{w: 8,    h: 4, mode: 3, exp3: 12, exp5: 0};
    vecs[7] = '{w: 3,    h: 3, mode: 2, exp3: 1,  exp5: 0};
    vecs[8] = '{w: 5,    h: 5, mode: 2, exp3: 9,  exp5: 1};
    vecs[9] = '{w: 12,   h: 9, mode: 2, exp3: 70, exp5: 40};

    width = 16'd8; height = 16'd6; in_valid = 1'b0; in_pixel = '0; need_rst = 1'b0;
    do_reset();
    check("reset out_valid", 200'({ov3, ov5}), 200'(0));
    check("reset frame_done", 200'({fd3, fd5}), 200'(0));
    check("reset cfg_err", 200'({err3, err5}), 200'(0));

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].w, vecs[v].h, vecs[v].mode, vecs[v].exp3, vecs[v].exp5,
                $sformatf("vec%0d", v));
      if (v == 0 && got3.size() > 0) begin
        check("first window tap00", 200'(got3[0][7:0]), 200'(8'h00));
        check("first window tap22", 200'(got3[0][64 +: 8]), 200'(8'h22));
`ifdef WINDOW_POS_EN
        check("first out_col/out_row", 200'({fc3, fr3}), 200'({16'd1, 16'd1}));
        check("last out_col/out_row", 200'({lc3, lr3}), 200'({16'd6, 16'd4}));
`endif
      end
      if (v == 1 && got5.size() > 0)
        check("K5 last window tap44", 200'(got5[got5.size()-1][192 +: 8]), 200'(8'h69));
    end

    // Abort a frame at row 3, then confirm a clean following frame.
    width = 16'd8; height = 16'd6;
    do_reset();
    cycle();
    fdc3 = 0; fdc5 = 0;
    for (int i = 0; i < 26; i++) begin
      in_valid = 1'b1;
      in_pixel = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    cycle();
    cycle();
    reset_n  = 1'b1;
    check("abort no frame_done", 200'(fdc3 + fdc5), 200'(0));
    check("abort reset out_valid", 200'({ov3, ov5}), 200'(0));
    need_rst = 1'b0;
    run_frame(8, 6, 3, 24, 8, "after_abort");

    for (int f = 0; f < 5; f++) begin
      int w, h, x3, x5;
      w  = $urandom_range(3, 14);
      h  = $urandom_range(3, 10);
      x3 = (h < 3 || w < 3) ? 0 : (w - 2) * (h - 2);
      x5 = (h < 5 || w < 5) ? 0 : (w - 4) * (h - 4);
      run_frame(w, h, 2, x3, x5, $sformatf("rand%0d_%0dx%0d", f, w, h));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
